// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_arb_pkg
// Brief    : Shared types, command codes and helpers for the SPI arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package spi_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

  // data_select command codes understood by the SPI master
  localparam logic [1:0] CMD_DUMMY = 2'b00;
  localparam logic [1:0] CMD_MEAS  = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_SRST  = 2'b11;

  // Width of a requester index / round-robin pointer
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : spi_rr_pick
// Brief    : Combinational rotating-priority selector. Scans req starting at
//            ptr and wrapping modulo N_REQ; the first asserted bit wins.
// Revision : 1.0 - initial release
// ============================================================================
module spi_rr_pick
  import spi_arb_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0]             req,
  input  logic [ptr_width(N_REQ)-1:0]  ptr,
  output logic [N_REQ-1:0]             winner,
  output logic [ptr_width(N_REQ)-1:0]  index,
  output logic                         valid
);

  localparam int PW = ptr_width(N_REQ);

  // Candidate index for each scan offset, i.e. (ptr + off) mod N_REQ
  logic [PW:0]   cand_sum  [N_REQ];
  logic [PW:0]   cand_wrap [N_REQ];
  logic [PW-1:0] cand      [N_REQ];

  generate
    for (genvar off = 0; off < N_REQ; off++) begin : g_cand
      assign cand_sum[off]  = {1'b0, ptr} + (PW+1)'(off);
      assign cand_wrap[off] = cand_sum[off] - (PW+1)'(N_REQ);
      assign cand[off]      = (cand_sum[off] >= (PW+1)'(N_REQ)) ?
                              cand_wrap[off][PW-1:0] : cand_sum[off][PW-1:0];
    end
  endgenerate

  // First asserted request in rotated order becomes the one-hot winner
  always_comb begin
    winner = '0;
    index  = '0;
    valid  = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      if (!valid && req[cand[off]]) begin
        valid              = 1'b1;
        index              = cand[off];
        winner[cand[off]]  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_arbiter
// Brief    : Round-robin arbiter sharing one SPI master between N_REQ
//            requesters. Owns chip-select sequencing: one setup cycle with
//            cs low before transfer, and a GAP_CYCLES cs-high gap after.
//            All outputs are registered (Moore).
//            Optional macro SPI_ARB_TIMEOUT_EN adds a transfer watchdog that
//            aborts XFER after TIMEOUT_CYCLES cycles without done.
// Revision : 1.0 - initial release
// ============================================================================
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [2*N_REQ-1:0]   req_sel,
  input  logic [2*N_REQ-1:0]   req_size,
  input  logic [N_REQ-1:0]     req_rx,
  input  logic                 done,
  output logic [1:0]           data_select,
  output logic [1:0]           data_size,
  output logic                 transfer,
  output logic                 receive,
  output logic                 cs,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     ack,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int PW = ptr_width(N_REQ);

  arb_state_t          state;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       owner;
  logic [PW-1:0]       next_ptr;
  logic [7:0]          gap_cnt;
  logic                lat_rx;

  logic [N_REQ-1:0]    pick_onehot;
  logic [PW-1:0]       pick_idx;
  logic                pick_valid;

  logic [1:0]          win_sel;
  logic [1:0]          win_size;
  logic                win_rx;

  logic                xfer_tmo;

  spi_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .winner (pick_onehot),
    .index  (pick_idx),
    .valid  (pick_valid)
  );

  // Route the current winner's command fields for latching in IDLE
  always_comb begin
    win_sel  = '0;
    win_size = '0;
    win_rx   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_onehot[i]) begin
        win_sel  = req_sel[2*i +: 2];
        win_size = req_size[2*i +: 2];
        win_rx   = req_rx[i];
      end
    end
  end

  // Pointer moves one past the owner so a repeat requester ranks last
  always_comb begin
    next_ptr = (owner == PW'(N_REQ-1)) ? '0 : owner + PW'(1);
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] tmo_cnt;

  // Watchdog counter: cleared on the way into XFER, counts each XFER cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == SETUP) begin
      tmo_cnt <= '0;
    end else if (state == XFER) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // A done arriving on the limit cycle takes precedence over the timeout
  always_comb begin
    xfer_tmo = !done && (tmo_cnt == TW'(TIMEOUT_CYCLES-1));
  end

  // Error pulse coincides with the forced ack
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= (state == XFER) && xfer_tmo;
    end
  end
`else
  assign xfer_tmo    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Arbitration FSM with registered SPI-side and requester-side outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cs          <= 1'b1;
      transfer    <= 1'b0;
      receive     <= 1'b0;
      data_select <= '0;
      data_size   <= '0;
      gnt         <= '0;
      ack         <= '0;
      busy        <= 1'b0;
      rr_ptr      <= '0;
      gap_cnt     <= '0;
      owner       <= '0;
      lat_rx      <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          cs       <= 1'b1;
          transfer <= 1'b0;
          if (pick_valid) begin
            state       <= SETUP;
            gnt         <= pick_onehot;
            owner       <= pick_idx;
            data_select <= win_sel;
            data_size   <= win_size;
            lat_rx      <= win_rx;
            cs          <= 1'b0;
            busy        <= 1'b1;
          end
        end
        SETUP: begin
          state    <= XFER;
          transfer <= 1'b1;
          receive  <= lat_rx;
        end
        XFER: begin
          if (done || xfer_tmo) begin
            state       <= GAP;
            ack         <= gnt;
            gnt         <= '0;
            cs          <= 1'b1;
            transfer    <= 1'b0;
            receive     <= 1'b0;
            data_select <= '0;
            data_size   <= '0;
            rr_ptr      <= next_ptr;
            gap_cnt     <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == 8'(GAP_CYCLES-1)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_arbiter
// Brief    : Directed self-checking bench for spi_arbiter (N_REQ=3,
//            GAP_CYCLES=2, TIMEOUT_CYCLES=16). Watchdog steps run only when
//            SPI_ARB_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_arbiter;
  import spi_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = '0;
  logic [5:0] req_sel = '0;
  logic [5:0] req_size = '0;
  logic [2:0] req_rx = '0;
  logic       done = 1'b0;
  logic [1:0] data_select;
  logic [1:0] data_size;
  logic       transfer;
  logic       receive;
  logic       cs;
  logic [2:0] gnt;
  logic [2:0] ack;
  logic       busy;
  logic       timeout_err;

  int errors = 0;
  int checks = 0;

  spi_arbiter #(
    .N_REQ          (3),
    .GAP_CYCLES     (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_sel     (req_sel),
    .req_size    (req_size),
    .req_rx      (req_rx),
    .done        (done),
    .data_select (data_select),
    .data_size   (data_size),
    .transfer    (transfer),
    .receive     (receive),
    .cs          (cs),
    .gnt         (gnt),
    .ack         (ack),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One arbitrated transaction with done three cycles after transfer rises.
  // Starts at the point the previous ack (or idle) is visible; counts the
  // cs-high cycles seen before the grant.
  task automatic txn(input logic [2:0] exp_gnt, input logic [1:0] exp_sel,
                     input int exp_hi, input string tag);
    int n;
    int hi;
    n  = 0;
    hi = 0;
    while (gnt === 3'b000 && n < 20) begin
      if (cs === 1'b1) hi++;
      tick();
      n++;
    end
    chk({tag, " gnt"}, {5'd0, gnt}, {5'd0, exp_gnt});
    chk({tag, " cs_high"}, hi[7:0], exp_hi[7:0]);
    chk({tag, " sel"}, {6'd0, data_select}, {6'd0, exp_sel});
    tick();
    chk({tag, " xfer"}, {7'd0, transfer}, 8'd1);
    chk({tag, " onehot"}, {7'd0, $onehot(gnt)}, 8'd1);
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk({tag, " ack"}, {5'd0, ack}, {5'd0, exp_gnt});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // ---------------- reset with a pending request ----------------
    req     = 3'b010;
    req_sel = {2'b00, CMD_READ, 2'b00};
    req_size = 6'b00_10_00;
    tick();
    tick();
    chk("rst cs",       {7'd0, cs},          8'd1);
    chk("rst transfer", {7'd0, transfer},    8'd0);
    chk("rst gnt",      {5'd0, gnt},         8'd0);
    chk("rst ack",      {5'd0, ack},         8'd0);
    chk("rst busy",     {7'd0, busy},        8'd0);
    chk("rst sel",      {6'd0, data_select}, 8'd0);
    chk("rst tmo",      {7'd0, timeout_err}, 8'd0);

    // ---------------- single request from requester 1 ----------------
    rst_n = 1'b1;
    tick();                                   // edge 0: SETUP
    chk("single gnt",   {5'd0, gnt},         8'h02);
    chk("single cs",    {7'd0, cs},          8'd0);
    chk("single setup", {7'd0, transfer},    8'd0);
    chk("single busy",  {7'd0, busy},        8'd1);
    chk("single sel",   {6'd0, data_select}, 8'h02);
    chk("single size",  {6'd0, data_size},   8'h02);
    tick();                                   // edge 1: XFER
    chk("single xfer",  {7'd0, transfer},    8'd1);
    chk("single rx",    {7'd0, receive},     8'd0);
    tick(); tick(); tick(); tick();           // edges 2..5
    chk("single hold",  {7'd0, transfer},    8'd1);
    chk("single noack", {5'd0, ack},         8'd0);
    done = 1'b1;
    tick();                                   // edge 6: done seen
    done = 1'b0;
    req  = 3'b000;
    chk("single ack",   {5'd0, ack},         8'h02);
    chk("single cs up", {7'd0, cs},          8'd1);
    chk("single x off", {7'd0, transfer},    8'd0);
    chk("single g off", {5'd0, gnt},         8'd0);
    chk("single sel0",  {6'd0, data_select}, 8'd0);
    tick();                                   // edge 7: GAP
    chk("single ack1",  {5'd0, ack},         8'd0);
    chk("single gapcs", {7'd0, cs},          8'd1);
    chk("single gapbz", {7'd0, busy},        8'd1);
    tick();                                   // edge 8: IDLE
    chk("single idle",  {7'd0, busy},        8'd0);
    chk("single idlcs", {7'd0, cs},          8'd1);

    // ---------------- receive path, requester 2, frozen command ----------------
    req_sel  = {CMD_DUMMY, 4'b0000};
    req_size = 6'b11_00_00;
    req_rx   = 3'b100;
    req      = 3'b100;
    tick();
    chk("rx gnt",       {5'd0, gnt},         8'h04);
    chk("rx size",      {6'd0, data_size},   8'h03);
    chk("rx sel",       {6'd0, data_select}, 8'h00);
    tick();
    chk("rx receive",   {7'd0, receive},     8'd1);
    req_size = 6'b01_00_00;
    req_sel  = {CMD_SRST, 4'b0000};
    req_rx   = 3'b000;
    tick();
    chk("rx frz size",  {6'd0, data_size},   8'h03);
    chk("rx frz sel",   {6'd0, data_select}, 8'h00);
    chk("rx frz rx",    {7'd0, receive},     8'd1);
    done = 1'b1;
    tick();
    req = 3'b000;
    chk("rx ack",       {5'd0, ack},         8'h04);
    chk("rx gap rcv",   {7'd0, receive},     8'd0);
    chk("rx gap size",  {6'd0, data_size},   8'd0);
    tick();                                   // stray done held into GAP
    done = 1'b0;
    chk("gap done ack", {5'd0, ack},         8'd0);
    chk("gap done cs",  {7'd0, cs},          8'd1);
    chk("gap done gnt", {5'd0, gnt},         8'd0);
    tick();
    chk("rx idle",      {7'd0, busy},        8'd0);
    done = 1'b1;                              // stray done in IDLE
    tick();
    done = 1'b0;
    chk("idle done bz", {7'd0, busy},        8'd0);
    chk("idle done ak", {5'd0, ack},         8'd0);
    chk("idle done cs", {7'd0, cs},          8'd1);

    // ---------------- contention: all three held ----------------
    req_sel  = {CMD_READ, CMD_MEAS, CMD_SRST};
    req_size = 6'b01_10_11;
    req      = 3'b111;
    txn(3'b001, CMD_SRST, 1, "rr0");
    txn(3'b010, CMD_MEAS, 3, "rr1");
    txn(3'b100, CMD_READ, 3, "rr2");
    txn(3'b001, CMD_SRST, 3, "rr3");
    req = 3'b000;
    tick();
    tick();
    chk("rr idle",      {7'd0, busy},        8'd0);

    // ---------------- reset mid-XFER (pointer is 1 here) ----------------
    req = 3'b101;
    tick();
    chk("mid gnt",      {5'd0, gnt},         8'h04);
    tick(); tick(); tick(); tick();
    chk("mid xfer",     {7'd0, transfer},    8'd1);
    rst_n = 1'b0;
    tick();
    chk("mid rst cs",   {7'd0, cs},          8'd1);
    chk("mid rst xfer", {7'd0, transfer},    8'd0);
    chk("mid rst gnt",  {5'd0, gnt},         8'd0);
    chk("mid rst ack",  {5'd0, ack},         8'd0);
    chk("mid rst busy", {7'd0, busy},        8'd0);
    rst_n = 1'b1;
    tick();                                   // pointer back at 0
    chk("post rst gnt", {5'd0, gnt},         8'h01);
    tick();
    req = 3'b000;                             // requester drops during XFER
    tick();
    chk("drop xfer",    {7'd0, transfer},    8'd1);
    chk("drop gnt",     {5'd0, gnt},         8'h01);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("drop ack",     {5'd0, ack},         8'h01);
    tick();
    tick();
    chk("drop idle",    {7'd0, busy},        8'd0);

`ifdef SPI_ARB_TIMEOUT_EN
    // ---------------- watchdog expiry ----------------
    req = 3'b001;
    tick();
    tick();                                   // XFER entry
    repeat (15) tick();
    chk("tmo pre ack",  {5'd0, ack},         8'd0);
    chk("tmo pre err",  {7'd0, timeout_err}, 8'd0);
    tick();                                   // 16 cycles after entry
    req = 3'b000;
    chk("tmo ack",      {5'd0, ack},         8'h01);
    chk("tmo err",      {7'd0, timeout_err}, 8'd1);
    chk("tmo cs",       {7'd0, cs},          8'd1);
    tick();
    chk("tmo err off",  {7'd0, timeout_err}, 8'd0);
    tick();

    // ---------------- done on the limit cycle wins ----------------
    req = 3'b001;
    tick();
    tick();
    repeat (15) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 3'b000;
    chk("tmo tie ack",  {5'd0, ack},         8'h01);
    chk("tmo tie err",  {7'd0, timeout_err}, 8'd0);
    tick();
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
